oka_233bit_seq_ctrl: RTL and testbench

Sequential GF(2)[x] multiplier controller for 233-bit binary-field operands.
- Time-shares one instance of the team's 117-bit combinational overlap-free Karatsuba core (OKA_117bit) across the three even/odd sub-products of a 233×233 multiply, over three consecutive cycles.
- Recombines the sub-products with overlap-free interleaving into a 465-bit product.
- Sits between the point-arithmetic scheduler (valid/ready upstream) and the field-reduction/result path (valid/ready downstream).

---
 rtl/oka_233bit_seq_ctrl.sv | 179 +++++++++++++++++
 tb/tb_oka_233bit_seq_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/oka_233bit_seq_ctrl.sv
// 233x233 GF(2)[x] multiplier: one shared 117-bit core over three cycles, then interleaved recombine.
// Build option OKA_SEQ_REDUCE_EN adds a reduction stage modulo x^233 + x^74 + 1.

module oka_117bit (
    input  logic [116:0] a,
    input  logic [116:0] b,
    output logic [232:0] p
);
    always_comb begin
        p = '0;
        for (int i = 0; i < 117; i++) begin
            if (b[i]) p = p ^ ({116'b0, a} << i);
        end
    end
endmodule

// state | meaning
// IDLE  | accept operands, core inputs zero
// MUL1  | core = ae*be, register P1
// MUL2  | core = ao*bo, register P2
// MUL3  | core = (ae^ao)*(be^bo), register P3
// COMB  | interleave P1/P2/P3 into y
// RED   | fold y modulo x^233+x^74+1 (OKA_SEQ_REDUCE_EN only)
// DONE  | hold y with out_valid until out_ready
module oka_233bit_seq_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [232:0] a,
    input  logic [232:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [464:0] y,
    output logic         busy
);
    localparam int N = 233;
    localparam int H = (N + 1) / 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL1,
        S_MUL2,
        S_MUL3,
        S_COMB,
`ifdef OKA_SEQ_REDUCE_EN
        S_RED,
`endif
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [N-1:0]   op_a, op_b;
    logic [H-1:0]   ae, ao, be, bo;
    logic [H-1:0]   core_a, core_b;
    logic [N-1:0]   core_p;
    logic [N-1:0]   p1;
    logic [N-2:0]   p2, p3;
    logic [2*N-2:0] y_comb, y_q;

    oka_117bit u_core (
        .a (core_a),
        .b (core_b),
        .p (core_p)
    );

    always_comb begin
        ae = '0;
        ao = '0;
        be = '0;
        bo = '0;
        for (int k = 0; k < H; k++) begin
            ae[k] = op_a[2*k];
            be[k] = op_b[2*k];
        end
        for (int k = 0; k < H - 1; k++) begin
            ao[k] = op_a[2*k+1];
            bo[k] = op_b[2*k+1];
        end
    end

    // P2[232] and the odd term at k=232 are structurally zero, so they are not kept.
    always_comb begin
        y_comb = '0;
        y_comb[0] = p1[0];
        for (int k = 1; k < N; k++) begin
            y_comb[2*k] = p1[k] ^ p2[k-1];
        end
        for (int k = 0; k < N - 1; k++) begin
            y_comb[2*k+1] = p3[k] ^ p1[k] ^ p2[k];
        end
    end

`ifdef OKA_SEQ_REDUCE_EN
    logic [231:0] hi;
    logic [305:0] fold1;
    logic [72:0]  hi2;
    logic [232:0] y_red;

    // Two folds: the first leaves up to x^305, the second lands below x^233.
    always_comb begin
        hi    = y_q[464:233];
        fold1 = {73'b0, y_q[232:0]} ^ {74'b0, hi} ^ {hi, 74'b0};
        hi2   = fold1[305:233];
        y_red = fold1[232:0] ^ {160'b0, hi2} ^ {86'b0, hi2, 74'b0};
    end
`endif

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        core_a    = '0;
        core_b    = '0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nx = S_MUL1;
            end
            S_MUL1: begin
                core_a   = ae;
                core_b   = be;
                state_nx = S_MUL2;
            end
            S_MUL2: begin
                core_a   = ao;
                core_b   = bo;
                state_nx = S_MUL3;
            end
            S_MUL3: begin
                core_a   = ae ^ ao;
                core_b   = be ^ bo;
                state_nx = S_COMB;
            end
`ifdef OKA_SEQ_REDUCE_EN
            S_COMB: state_nx = S_RED;
            S_RED:  state_nx = S_DONE;
`else
            S_COMB: state_nx = S_DONE;
`endif
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            op_a  <= '0;
            op_b  <= '0;
            p1    <= '0;
            p2    <= '0;
            p3    <= '0;
            y_q   <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && in_valid) begin
                op_a <= a;
                op_b <= b;
            end
            if (state == S_MUL1) p1 <= core_p;
            if (state == S_MUL2) p2 <= core_p[N-2:0];
            if (state == S_MUL3) p3 <= core_p[N-2:0];
            if (state == S_COMB) y_q <= y_comb;
`ifdef OKA_SEQ_REDUCE_EN
            if (state == S_RED) y_q <= {232'b0, y_red};
`endif
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_oka_233bit_seq_ctrl.sv
// Directed and random checks for oka_233bit_seq_ctrl against a shift-XOR reference model.
// Honours OKA_SEQ_REDUCE_EN for expected values and latency.

module tb_oka_233bit_seq_ctrl;
`ifdef OKA_SEQ_REDUCE_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [232:0] a, b;
    logic         out_valid;
    logic         out_ready;
    logic [464:0] y;
    logic         busy;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    oka_233bit_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [464:0] got, input logic [464:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [464:0] ref_prod(input logic [232:0] x, input logic [232:0] z);
        logic [464:0] r;
        r = '0;
        for (int i = 0; i < 233; i++) begin
            if (z[i]) r = r ^ ({232'b0, x} << i);
        end
`ifdef OKA_SEQ_REDUCE_EN
        for (int i = 464; i >= 233; i--) begin
            if (r[i]) begin
                r[i]       = 1'b0;
                r[i-159]   = ~r[i-159];
                r[i-233]   = ~r[i-233];
            end
        end
`endif
        return r;
    endfunction

    function automatic logic [232:0] rnd233();
        logic [255:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return w[232:0];
    endfunction

    task automatic run_txn(input logic [232:0] ta, input logic [232:0] tb_in, input int stall,
                           output logic [464:0] yo);
        int guard;
        int cyc;
        guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        chk("ready_wait", 465'(in_ready), 465'(1));
        a = ta;
        b = tb_in;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = '0;
        b = '0;
        chk("ready_drop", 465'(in_ready), 465'(0));
        chk("busy_high", 465'(busy), 465'(1));
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            step();
            cyc++;
        end
        chk("latency", 465'(cyc), 465'(LAT));
        yo = y;
        for (int s = 0; s < stall; s++) begin
            step();
            chk("hold_y", y, yo);
            chk("hold_valid", 465'(out_valid), 465'(1));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("valid_drop", 465'(out_valid), 465'(0));
        chk("busy_low", 465'(busy), 465'(0));
    endtask

    initial begin
        logic [464:0] yo, ex;
        logic [232:0] ra, rb;
        logic [464:0] q[$];
        int acc, got, quiet;

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_ready", 465'(in_ready), 465'(1));
        chk("rst_valid", 465'(out_valid), 465'(0));
        chk("rst_busy", 465'(busy), 465'(0));
        chk("rst_y", y, '0);

        run_txn(233'd1, 233'd1, 0, yo);
        chk("one_x_one", yo, 465'd1);
        run_txn(233'd2, 233'd2, 2, yo);
        chk("x_x", yo, 465'd4);
        run_txn(233'd3, 233'd3, 0, yo);
        chk("xp1_sq", yo, 465'd5);

        ra = '0;
        ra[232] = 1'b1;
        ex = '0;
`ifdef OKA_SEQ_REDUCE_EN
        ex[231] = 1'b1;
        ex[146] = 1'b1;
        ex[72]  = 1'b1;
`else
        ex[464] = 1'b1;
`endif
        run_txn(ra, ra, 1, yo);
        chk("top_bit", yo, ex);

        for (int i = 0; i < 1000; i++) begin
            ra = rnd233();
            rb = rnd233();
            run_txn(ra, rb, int'($urandom_range(0, 10)), yo);
            chk("random", yo, ref_prod(ra, rb));
        end

        // Streaming: in_valid always high, fresh operands every cycle.
        acc = 0;
        got = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 80; c++) begin
            if (out_valid) begin
                if (q.size() > 0) chk("stream_y", y, q.pop_front());
                else chk("stream_extra", 465'(out_valid), 465'(0));
                got++;
            end
            a = rnd233();
            b = rnd233();
            if (in_ready) begin
                q.push_back(ref_prod(a, b));
                acc++;
            end
            step();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) begin
                if (q.size() > 0) chk("stream_y", y, q.pop_front());
                else chk("stream_extra", 465'(out_valid), 465'(0));
                got++;
            end
            step();
        end
        out_ready = 1'b0;
        chk("stream_lost", 465'(q.size()), 465'(0));
        chk("stream_count", 465'(got), 465'(acc));
        chk("stream_accepts", 465'(acc >= 10), 465'(1));

        // Reset during MUL2.
        a = rnd233();
        b = rnd233();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_ready", 465'(in_ready), 465'(1));
        chk("midrst_busy", 465'(busy), 465'(0));
        chk("midrst_valid", 465'(out_valid), 465'(0));
        chk("midrst_y", y, '0);
        quiet = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (out_valid) quiet++;
        end
        chk("midrst_no_output", 465'(quiet), 465'(0));
        run_txn(233'd3, 233'd3, 0, yo);
        chk("post_rst", yo, 465'd5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
